// File: rtl/ptr_addr_seq.sv
// Pointer-addressed memory access sequencer: reads Pn, issues one memory access
// from it, then optionally writes back the pre/post adjusted pointer.
module ptr_addr_seq #(
  parameter logic [11:0] STEP     = 12'd1,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  n,
  input  logic [1:0]  op,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  psel0,
  input  logic [11:0] qp0,
  output logic [1:0]  pselw,
  output logic        wep,
  output logic [11:0] d12,
  output logic [11:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_MEM  = 3'd2;
  localparam logic [2:0] S_WB   = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_PDEC = 2'b10;

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  logic [2:0]  state_q, state_d;
  logic [1:0]  n_q, n_d;
  logic [1:0]  op_q, op_d;
  logic [11:0] ptr_q, ptr_d;
  logic [7:0]  wait_q, wait_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  psel0_q, psel0_d;
  logic [1:0]  pselw_q, pselw_d;
  logic        wep_q, wep_d;
  logic [11:0] d12_q, d12_d;
  logic [11:0] mem_addr_q, mem_addr_d;
  logic        mem_req_q, mem_req_d;
  logic [7:0]  wait_inc_s;

  assign wait_inc_s = wait_q + 8'd1;

  // Sequencer next-state, pointer capture and ack timeout.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    op_d    = op_q;
    ptr_d   = ptr_q;
    wait_d  = wait_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = n;
          op_d    = op;
          state_d = S_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        ptr_d   = qp0;
        wait_d  = 8'd0;
        state_d = S_MEM;
      end
      S_MEM: begin
        if (mem_ack) begin
          state_d = (op_q == OP_NONE) ? S_FIN : S_WB;
        end else if (wait_inc_s == WAIT_LIM) begin
          wait_d  = wait_inc_s;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d  = wait_inc_s;
        end
      end
      S_WB:    state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_FIN);
    psel0_d   = (state_d == S_RD) ? n_d : 2'd0;
    pselw_d   = (state_d == S_WB) ? n_q : 2'd0;
    wep_d     = (state_d == S_WB);
    mem_req_d = (state_d == S_MEM);
    if (state_d == S_WB) begin
      d12_d = (op_q == OP_INC) ? (ptr_q + STEP) : (ptr_q - STEP);
    end else begin
      d12_d = 12'd0;
    end
    if (state_d != S_MEM) begin
      mem_addr_d = 12'd0;
    end else if (state_q == S_RD) begin
      // ptr is only being latched on this edge, so take the address from qp0.
      mem_addr_d = (op_q == OP_PDEC) ? (qp0 - STEP) : qp0;
    end else begin
      mem_addr_d = mem_addr_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      n_q        <= 2'd0;
      op_q       <= 2'd0;
      ptr_q      <= 12'd0;
      wait_q     <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      psel0_q    <= 2'd0;
      pselw_q    <= 2'd0;
      wep_q      <= 1'b0;
      d12_q      <= 12'd0;
      mem_addr_q <= 12'd0;
      mem_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      op_q       <= op_d;
      ptr_q      <= ptr_d;
      wait_q     <= wait_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      psel0_q    <= psel0_d;
      pselw_q    <= pselw_d;
      wep_q      <= wep_d;
      d12_q      <= d12_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign psel0    = psel0_q;
  assign pselw    = pselw_q;
  assign wep      = wep_q;
  assign d12      = d12_q;
  assign mem_addr = mem_addr_q;
  assign mem_req  = mem_req_q;

endmodule

// File: tb/tb_ptr_addr_seq.sv
// Bench for ptr_addr_seq: register-file model, directed sequences, and a
// negedge monitor that checks memory, writeback and completion against queues.
module tb_ptr_addr_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  n_i;
  logic [1:0]  op_i;
  logic        busy, done, err;
  logic [1:0]  psel0, pselw;
  logic [11:0] qp0, d12, mem_addr;
  logic        wep, mem_req, mem_ack;

  logic [11:0] rf [4];
  logic        tb_we;
  logic [1:0]  tb_sel;
  logic [11:0] tb_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [11:0] exp_addr_q [$];
  logic [13:0] exp_wr_q   [$];
  bit          exp_end_q  [$];

  logic        req_prev;
  logic [11:0] addr_prev;

  always #5 clk = ~clk;

  ptr_addr_seq #(.STEP(12'd1), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n(n_i), .op(op_i),
    .busy(busy), .done(done), .err(err), .psel0(psel0), .qp0(qp0),
    .pselw(pselw), .wep(wep), .d12(d12), .mem_addr(mem_addr),
    .mem_req(mem_req), .mem_ack(mem_ack)
  );

  assign qp0 = rf[psel0];

  always @(posedge clk) begin
    if (wep) rf[pselw] <= d12;
    else if (tb_we) rf[tb_sel] <= tb_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (mem_req) begin
      if (!req_prev) begin
        if (exp_addr_q.size() == 0) chk("unexpected_mem_req", 32'd1, 32'd0);
        else chk("mem_addr", {20'd0, mem_addr}, {20'd0, exp_addr_q.pop_front()});
      end else begin
        chk("mem_addr_stable", {20'd0, mem_addr}, {20'd0, addr_prev});
      end
    end
    req_prev  <= mem_req;
    addr_prev <= mem_addr;
    if (wep) begin
      if (exp_wr_q.size() == 0) chk("unexpected_wep", 32'd1, 32'd0);
      else chk("writeback_sel_data", {18'd0, pselw, d12}, {18'd0, exp_wr_q.pop_front()});
    end
    if (done || err) begin
      chk("done_err_exclusive", {31'd0, done & err}, 32'd0);
      if (exp_end_q.size() == 0) chk("unexpected_end", 32'd1, 32'd0);
      else chk("end_is_err", {31'd0, err}, {31'd0, exp_end_q.pop_front()});
    end
  end

  task automatic preload(input logic [1:0] idx, input logic [11:0] val);
    @(negedge clk);
    tb_we = 1'b1; tb_sel = idx; tb_data = val;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // ack_at: MEM cycle (1-based) in which mem_ack is driven, 0 = never.
  task automatic run_seq(input logic [1:0] n, input logic [1:0] op, input int ack_at,
                         input bit early_ack, input bit poke, input bit is_err,
                         input logic [11:0] ea, input logic [11:0] ed, input int exp_lat);
    int m = 0;
    int lat = 0;
    int c = 0;
    exp_addr_q.push_back(ea);
    if (!is_err && op != 2'b00) exp_wr_q.push_back({n, ed});
    exp_end_q.push_back(is_err);
    @(negedge clk);
    start = 1'b1; n_i = n; op_i = op;
    while (lat == 0 && c < 40) begin
      @(negedge clk);
      c++;
      mem_ack = 1'b0;
      if (c == 1) begin
        start   = 1'b0;
        mem_ack = early_ack;
      end
      if (poke && c == 2) begin start = 1'b1; n_i = ~n; op_i = 2'b01; end
      if (poke && c == 3) start = 1'b0;
      if (mem_req) begin
        m++;
        if (m == ack_at) mem_ack = 1'b1;
      end
      if (done || err) lat = c;
    end
    mem_ack = 1'b0;
    start   = 1'b0;
    chk("latency", lat, exp_lat);
    @(negedge clk);
    chk("idle_after_seq", {31'd0, busy}, 32'd0);
    if (poke) begin
      repeat (3) @(negedge clk);
      chk("start_while_busy_ignored", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; n_i = 2'd0; op_i = 2'd0; mem_ack = 1'b0;
    tb_we = 1'b0; tb_sel = 2'd0; tb_data = 12'd0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {15'd0, busy, done, err, wep, mem_req, psel0, pselw, 8'd0},
        32'd0);
    chk("rst_d12_addr", {8'd0, d12, mem_addr}, 32'd0);
    rst_n = 1'b1;
    preload(2'd0, 12'h456);
    preload(2'd1, 12'h000);
    preload(2'd2, 12'h123);
    preload(2'd3, 12'hFFF);

    run_seq(2'd2, 2'b01, 1, 1'b0, 1'b0, 1'b0, 12'h123, 12'h124, 4);
    chk("P2_post_inc", {20'd0, rf[2]}, 32'h124);
    run_seq(2'd1, 2'b10, 1, 1'b0, 1'b0, 1'b0, 12'hFFF, 12'hFFF, 4);
    chk("P1_pre_dec_wrap", {20'd0, rf[1]}, 32'hFFF);
    run_seq(2'd3, 2'b01, 1, 1'b0, 1'b0, 1'b0, 12'hFFF, 12'h000, 4);
    chk("P3_post_inc_wrap", {20'd0, rf[3]}, 32'h000);
    run_seq(2'd0, 2'b11, 3, 1'b1, 1'b1, 1'b0, 12'h456, 12'h455, 6);
    chk("P0_post_dec", {20'd0, rf[0]}, 32'h455);
    preload(2'd0, 12'h456);
    run_seq(2'd0, 2'b00, 1, 1'b0, 1'b0, 1'b0, 12'h456, 12'h000, 3);
    chk("P0_op_none_unchanged", {20'd0, rf[0]}, 32'h456);
    run_seq(2'd2, 2'b01, 0, 1'b0, 1'b0, 1'b1, 12'h124, 12'h000, 6);
    chk("P2_timeout_unchanged", {20'd0, rf[2]}, 32'h124);

    // Reset during MEM: immediate idle outputs and no writeback.
    exp_addr_q.push_back(12'hFFF);
    @(negedge clk);
    start = 1'b1; n_i = 2'd1; op_i = 2'b01;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("in_mem_before_reset", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_outputs", {17'd0, busy, done, err, wep, mem_req, mem_addr[9:0]}, 32'd0);
    chk("reset_mid_addr_hi", {30'd0, mem_addr[11:10]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("P1_no_write_after_reset", {20'd0, rf[1]}, 32'hFFF);
    run_seq(2'd1, 2'b10, 1, 1'b0, 1'b0, 1'b0, 12'hFFE, 12'hFFE, 4);
    chk("P1_after_reset_run", {20'd0, rf[1]}, 32'hFFE);

    repeat (2) @(negedge clk);
    chk("exp_addr_drained", exp_addr_q.size(), 32'd0);
    chk("exp_wr_drained", exp_wr_q.size(), 32'd0);
    chk("exp_end_drained", exp_end_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
